// File: rtl/bpu_pkg.sv
// Shared constants for the branch predict unit: EX next-PC type codes,
// IF mux select codes, 2-bit counter states and the counter step rule.
package bpu_pkg;

  // Next-PC type carried by the EX instruction
  localparam logic [1:0] PCPlus4 = 2'b00;
  localparam logic [1:0] Branch  = 2'b01;
  localparam logic [1:0] Jump    = 2'b10;

  // next_type codes decoded by the IF next-PC mux
  localparam logic [1:0] NT_SEQ   = 2'b00;  // follow fetch
  localparam logic [1:0] NT_EXPC4 = 2'b01;  // EX PC+4 (predicted T, was NT)
  localparam logic [1:0] NT_JUMP  = 2'b10;  // jump target
  localparam logic [1:0] NT_BTGT  = 2'b11;  // branch target (predicted NT, was T)

  // Saturating counter states; prediction is the MSB
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [1:0] INIT_CNT_DEF = CNT_WNT;

  // One training step: move toward taken or not-taken, clamping at the ends
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic inc);
    logic [1:0] nxt;
    nxt = cnt;
    if (inc && cnt != CNT_ST)
      nxt = cnt + 2'd1;
    else if (!inc && cnt != CNT_SNT)
      nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// One PHT entry: 2-bit saturating counter, trained when en is high,
// asynchronously returned to INIT by rst.
module bpu_sat_counter
  import bpu_pkg::*;
#(
  parameter logic [1:0] INIT = INIT_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  output logic [1:0] cnt
);

  // Counter state; reset wins over any update sampled at the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= INIT;
    else if (en)
      cnt <= sat_step(cnt, inc);
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor and resolver.
// IF looks up a table of 2-bit saturating counters; EX resolution selects
// the next-PC source, raises flush on a wrong path and trains the table.
// Build option BPU_GSHARE_EN: XOR the PC index with a global history
// register of resolved branch outcomes (gshare); otherwise bimodal.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = INIT_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [1:0]        ex_npc_type,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_pred_taken,
  input  logic              ex_taken,
  output logic [1:0]        next_type,
  output logic              flush
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       cnt [DEPTH];
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_en;

  // Only valid resolved branches train the table (and the history)
  assign upd_en = ex_valid && (ex_npc_type == Branch);

`ifdef BPU_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // Non-speculative history: shifts at the same edge as the PHT update,
  // so the update index below still sees the pre-shift value
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ghr <= '0;
    else if (upd_en)
      ghr <= {ghr[IDX_W-2:0], ex_taken};
  end

  assign lk_idx  = if_pc[IDX_W+1:2] ^ ghr;
  assign upd_idx = ex_pc[IDX_W+1:2] ^ ghr;
`else
  assign lk_idx  = if_pc[IDX_W+1:2];
  assign upd_idx = ex_pc[IDX_W+1:2];
`endif

  // Word-offset bits and upper PC bits do not take part in indexing
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[ADDR_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[ADDR_W-1:IDX_W+2], ex_pc[1:0]};

  // Pattern history table: one counter per index
  for (genvar i = 0; i < DEPTH; i++) begin : g_pht
    bpu_sat_counter #(.INIT(INIT_CNT)) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (upd_en && (upd_idx == IDX_W'(i))),
      .inc (ex_taken),
      .cnt (cnt[i])
    );
  end

  // Lookup reads the registered counters, so a same-cycle update at the
  // same index is only visible from the next cycle
  assign if_pred_taken = rst ? INIT_CNT[1] : cnt[lk_idx][1];

  // Next-PC source and flush, purely from the EX stage this cycle
  always_comb begin
    next_type = NT_SEQ;
    flush     = 1'b0;
    if (!rst && ex_valid) begin
      case (ex_npc_type)
        Jump: begin
          next_type = NT_JUMP;
          flush     = 1'b1;
        end
        Branch: begin
          if (ex_taken != ex_pred_taken) begin
            next_type = ex_taken ? NT_BTGT : NT_EXPC4;
            flush     = 1'b1;
          end
        end
        default: begin
          next_type = NT_SEQ;
          flush     = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Dynamic branch predictor and resolver for the 5-stage pipelined CPU; replaces fixed predict-not-taken next-PC selection.
- IF stage looks up a pattern history table (PHT) of 2-bit saturating counters and gets a taken/not-taken prediction.
- EX stage presents the resolved branch or jump. The block selects the next-PC source, flags a flush on misprediction, and trains the PHT.

Parameters:
- ADDR_W, 32, PC width.
- IDX_W, 6, PHT index width; depth = 2**IDX_W entries.
- INIT_CNT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  ADDR_W  fetch PC
- if_pred_taken  out  1  prediction for if_pc (combinational from PHT)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_npc_type  in  2  00 PC+4, 01 Branch, 10 Jump, 11 reserved (treated as PC+4)
- ex_pc  in  ADDR_W  PC of the EX instruction
- ex_pred_taken  in  1  prediction carried down with the instruction
- ex_taken  in  1  resolved branch condition
- next_type  out  2  00 follow fetch, 01 EX PC+4, 10 jump target, 11 branch target
- flush  out  1  kill IF/ID and ID/EX contents this cycle

Behaviour:
- PHT index: idx = if_pc[IDX_W+1:2] for lookup; ex_pc[IDX_W+1:2] for update. Bits [1:0] are ignored.
- Counter states:
  - 00 strong-NT
  - 01 weak-NT
  - 10 weak-T
  - 11 strong-T
- Prediction = counter MSB.
- Update on rising clk when ex_valid && ex_npc_type==Branch:
  - ex_taken=1: increment, saturating at 11.
  - ex_taken=0: decrement, saturating at 00.
- Jumps, PC+4 and invalid slots never touch the PHT.
- next_type / flush are combinational from EX inputs, same cycle:
  - !ex_valid or PC+4/reserved -> 00, flush 0.
  - Jump -> 10, flush 1.
  - Branch, ex_taken == ex_pred_taken -> 00, flush 0 (prediction correct; IF already on the right path).
  - Branch, predicted T / actual NT -> 01, flush 1.
  - Branch, predicted NT / actual T -> 11, flush 1.
- Read-during-write at the same index: lookup returns the pre-update value. The new value is visible from the next cycle (1-cycle training latency). No bypass.
- Reset (async, any time, including mid-update):
  - All counters go to INIT_CNT immediately.
  - Outputs while rst is high: next_type 00, flush 0, if_pred_taken = INIT_CNT[1].
  - An update coinciding with reset release is discarded.
- 2-bit output encodings are fixed; the IF mux decodes them.

Optional Feature:
- Macro BPU_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register ghr, reset 0.
  - Lookup and update index = pc[IDX_W+1:2] ^ ghr.
  - ghr shifts left on each resolved Branch with ex_taken entering at bit 0, updated at the same edge as the PHT.
  - History is non-speculative; no checkpoint or repair is needed.
  - The update index uses ghr before the shift.
- Undefined: pure PC-indexed bimodal table; ghr absent.

Decomposition:
- Package bpu_pkg holds:
  - NPC type localparams: PCPlus4, Branch, Jump.
  - next_type codes: NT_SEQ, NT_EXPC4, NT_JUMP, NT_BTGT.
  - Counter state constants and INIT_CNT default.
- Sub-module bpu_sat_counter: 2-bit saturating counter with inc/dec enable and async reset. The PHT instantiates 2**IDX_W of them via generate.

Test Plan:
- Reset then if_pc=0x0000_0040 -> if_pred_taken=0 (INIT 01), next_type 00, flush 0.
- Branch at ex_pc=0x40, ex_pred_taken=0, ex_taken=1 -> next_type 11, flush 1. After 1 edge the counter is 10, so a lookup of 0x40 gives pred 1. Two more taken resolutions -> counter saturates at 11.
- Predicted taken, ex_taken=0 at ex_pc=0x44 -> next_type 01, flush 1. With the counter at 11, four not-taken resolutions -> counter 00 and stays there.
- Jump with ex_valid=1 -> next_type 10, flush 1, PHT unchanged. The same Jump with ex_valid=0 -> 00, 0.
- Lookup and update of idx 5 in the same cycle -> old prediction returned that cycle, new one next cycle. rst asserted mid-update -> all entries read INIT next cycle.
- BPU_GSHARE_EN: three taken branches give ghr=0b000111. A lookup of pc 0x40 then uses idx 0x10^0x07=0x17, which must hold INIT.
